preg_reclaim: RTL and testbench

PREG_RECLAIM -- requirements
Module: preg_reclaim

---
 rtl/preg_reclaim.sv | 72 +++++++
 tb/tb_preg_reclaim.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/preg_reclaim.sv
// Physical-register reclaim queue between ROB retire and the freelist.
// Optional PREG_RECLAIM_BYPASS_EN: empty-queue retire goes straight out.
module preg_reclaim #(
  parameter int NUM_PR  = 64,
  parameter int DEPTH   = 8,
  parameter int ZERO_PR = 31,
  localparam int TW = $clog2(NUM_PR),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic          retire_valid,
  input  logic [TW-1:0] retire_T_old,
  input  logic          retire_has_dest,
  output logic          retire_ready,
  output logic          free_valid,
  output logic [TW-1:0] free_T,
  input  logic          free_ready,
  output logic [AW:0]   count
);

  logic [TW-1:0] mem [DEPTH];
  logic [AW:0]   head;
  logic [AW:0]   tail;
  logic          empty;
  logic          full;
  logic          qual;
  logic          byp;
  logic          push;
  logic          pop;

  assign empty = head == tail;
  assign full  = (head[AW] != tail[AW]) &&
                 (head[AW-1:0] == tail[AW-1:0]);
  assign count = tail - head;

  // R31's tag is architectural zero and must never reach the freelist
  assign qual = retire_valid && retire_has_dest &&
                (retire_T_old != TW'(ZERO_PR));

`ifdef PREG_RECLAIM_BYPASS_EN
  assign byp    = empty && qual;
  assign free_T = empty ? retire_T_old : mem[head[AW-1:0]];
`else
  assign byp    = 1'b0;
  assign free_T = mem[head[AW-1:0]];
`endif

  assign free_valid   = !empty || byp;
  assign retire_ready = !full || (free_valid && free_ready);

  // a bypassed tag taken by the freelist is never stored
  assign push = en && retire_valid && retire_ready && qual &&
                !(byp && free_ready);
  assign pop  = en && !empty && free_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push) tail <= tail + (AW+1)'(1);
      if (pop)  head <= head + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[tail[AW-1:0]] <= retire_T_old;
  end

endmodule

// File: tb/tb_preg_reclaim.sv
// Bench for preg_reclaim: queue-based model plus directed literal checks.
// Random traffic is checked against the model on every falling edge.
module tb_preg_reclaim;

  localparam int DEPTH = 8;

  logic       clock;
  logic       reset;
  logic       en;
  logic       retire_valid;
  logic [5:0] retire_T_old;
  logic       retire_has_dest;
  logic       retire_ready;
  logic       free_valid;
  logic [5:0] free_T;
  logic       free_ready;
  logic [3:0] count;

  int n_chk;
  int n_fail;

  logic [5:0] q[$];
  logic [5:0] popped[$];
  logic [5:0] sent[$];

  preg_reclaim dut (
    .clock(clock),
    .reset(reset),
    .en(en),
    .retire_valid(retire_valid),
    .retire_T_old(retire_T_old),
    .retire_has_dest(retire_has_dest),
    .retire_ready(retire_ready),
    .free_valid(free_valid),
    .free_T(free_T),
    .free_ready(free_ready),
    .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit m_qual();
    return retire_valid && retire_has_dest &&
           retire_T_old != 6'd31;
  endfunction

  function automatic bit m_byp();
`ifdef PREG_RECLAIM_BYPASS_EN
    return q.size() == 0 && m_qual();
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_fv();
    return q.size() != 0 || m_byp();
  endfunction

  function automatic bit m_rr();
    return q.size() < DEPTH || (m_fv() && free_ready);
  endfunction

  function automatic logic [5:0] m_ft();
    return q.size() != 0 ? q[0] : retire_T_old;
  endfunction

  // model update: decide handshakes from pre-edge state, then pop/push
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
    end else begin
      bit rr, fv, byp, pop, push;
      logic [5:0] t;
      rr   = m_rr();
      fv   = m_fv();
      byp  = m_byp();
      t    = retire_T_old;
      pop  = en && fv && free_ready;
      push = en && retire_valid && rr && m_qual();
      if (!(byp && pop)) begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(t);
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      chk("retire_ready", retire_ready, m_rr());
      chk("free_valid", free_valid, m_fv());
      if (m_fv()) chk("free_T", free_T, m_ft());
      chk("count", count, q.size());
      if (en && free_valid && free_ready) popped.push_back(free_T);
    end
  end

  task automatic drive(input logic rv, input logic [5:0] t,
                       input logic hd, input logic fr);
    en              = 1'b1;
    retire_valid    = rv;
    retire_T_old    = t;
    retire_has_dest = hd;
    free_ready      = fr;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int k;
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    k = 0;
    while (count != 0 && k < 60) begin
      tick();
      k++;
    end
    tick();
    chk("drain_count", count, 0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    drive(1'b0, 6'd0, 1'b0, 1'b0);
    #3;
    chk("rst_count", count, 0);
    chk("rst_free_valid", free_valid, 0);
    chk("rst_retire_ready", retire_ready, 1);
    @(posedge clock);
    #1 reset = 1'b0;

`ifdef PREG_RECLAIM_BYPASS_EN
    drive(1'b1, 6'd42, 1'b1, 1'b1);
    #1;
    chk("byp_free_valid", free_valid, 1);
    chk("byp_free_T", free_T, 42);
    tick();
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    #1;
    chk("byp_count", count, 0);
`else
    drive(1'b1, 6'd40, 1'b1, 1'b1);
    tick();
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    chk("lat_free_valid", free_valid, 1);
    chk("lat_free_T", free_T, 40);
    tick();
    chk("lat_count", count, 0);
`endif

    drive(1'b1, 6'd31, 1'b1, 1'b1);
    tick();
    drive(1'b1, 6'd5, 1'b0, 1'b1);
    tick();
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    chk("nopush_count", count, 0);
    chk("nopush_ready", retire_ready, 1);

    popped.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 6'(10 + i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 6'd0, 1'b0, 1'b0);
    chk("full_count", count, 8);
    chk("full_ready", retire_ready, 0);
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    #1;
    chk("popcyc_ready", retire_ready, 1);
    drain();
    chk("fill_npop", popped.size(), 8);
    for (int i = 0; i < 8 && i < popped.size(); i++)
      chk("fill_order", popped[i], 10 + i);

    popped.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 6'(50 + i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 6'd20, 1'b1, 1'b1);
    #1;
    chk("simul_ready", retire_ready, 1);
    tick();
    drive(1'b0, 6'd0, 1'b0, 1'b0);
    chk("simul_count", count, 8);
    drain();
    chk("simul_npop", popped.size(), 9);
    for (int i = 0; i < 8 && i < popped.size(); i++)
      chk("simul_order", popped[i], 50 + i);
    if (popped.size() > 8) chk("simul_last", popped[8], 20);

    popped.delete();
    sent.delete();
    begin
      int i, it;
      bit acc;
      i  = 0;
      it = 0;
      while (i < 20 && it < 400) begin
        drive(1'b1, 6'(1 + i), 1'b1, 1'($urandom_range(0, 1)));
        #1;
        acc = retire_ready;
        tick();
        if (acc) begin
          sent.push_back(6'(1 + i));
          i++;
        end
        it++;
      end
      chk("wrap_sent", i, 20);
    end
    drain();
    chk("wrap_npop", popped.size(), sent.size());
    for (int i = 0; i < sent.size() && i < popped.size(); i++)
      chk("wrap_order", popped[i], sent[i]);

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 6'(40 + i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 6'd0, 1'b0, 1'b0);
    chk("pre_rst_count", count, 5);
    #2;
    reset = 1'b1;
    #1;
    chk("async_count", count, 0);
    chk("async_free_valid", free_valid, 0);
    chk("async_ready", retire_ready, 1);
    @(posedge clock);
    #1 reset = 1'b0;

    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 6'd31
                                         : 6'($urandom_range(0, 63)),
            1'($urandom_range(0, 4) != 0),
            1'($urandom_range(0, 2) != 0));
      en = 1'($urandom_range(0, 9) != 0);
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
